cordic_share_arbiter: RTL and testbench

- Shares the single vectoring CORDIC and single rotation CORDIC between NUM_REQ requesters, e.g. the estimation dot-product engine, the weight-update engine and the normalisation engine.
- Round-robin arbitration; the winner holds both cores until it drops req and all of its issued operations have returned.
- A flush reset (cordic_nrst low) is applied to the cores on every ownership change.
- Sits between the requester engines and the CORDIC instances at top level.

---
 rtl/cordic_share_arbiter_pkg.sv | 24 ++
 rtl/cordic_share_arbiter_if.sv | 36 +++
 rtl/cordic_share_arbiter_rr_pick.sv | 38 +++
 rtl/cordic_share_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cordic_share_arbiter.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_share_arbiter_pkg.sv
// Shared definitions for the CORDIC sharing arbiter: FSM encoding, quadrant
// width and a constant clog2 helper.
package cordic_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_OWN   = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    localparam int CORDIC_QUAD_W = 2;

    // Never returns less than 1 so a width derived from it is always legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/cordic_share_arbiter_if.sv
// Core-side bus between the arbiter (master) and the shared vectoring and
// rotation CORDIC instances (slave).
interface cordic_share_arbiter_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16
) ();
    import cordic_share_arbiter_pkg::*;

    logic                     cordic_nrst;
    logic                     cordic_vec_en;
    logic [DATA_WIDTH-1:0]    cordic_vec_xin;
    logic [DATA_WIDTH-1:0]    cordic_vec_yin;
    logic                     cordic_rot_en;
    logic [DATA_WIDTH-1:0]    cordic_rot_xin;
    logic [DATA_WIDTH-1:0]    cordic_rot_yin;
    logic [ANGLE_WIDTH-1:0]   cordic_rot_angle_in;
    logic [CORDIC_QUAD_W-1:0] cordic_rot_quad_in;
    logic                     cordic_rot_angle_microRot_n;
    logic                     cordic_vec_opvld;
    logic                     cordic_rot_opvld;

    modport master (
        output cordic_nrst, cordic_vec_en, cordic_vec_xin, cordic_vec_yin,
               cordic_rot_en, cordic_rot_xin, cordic_rot_yin,
               cordic_rot_angle_in, cordic_rot_quad_in, cordic_rot_angle_microRot_n,
        input  cordic_vec_opvld, cordic_rot_opvld
    );

    modport slave (
        input  cordic_nrst, cordic_vec_en, cordic_vec_xin, cordic_vec_yin,
               cordic_rot_en, cordic_rot_xin, cordic_rot_yin,
               cordic_rot_angle_in, cordic_rot_quad_in, cordic_rot_angle_microRot_n,
        output cordic_vec_opvld, cordic_rot_opvld
    );

endinterface

// File: rtl/cordic_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request searching upward from
// ptr+1 with wrap-around, returned both one-hot and as an index.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int             j;
    logic [IDX_W-1:0] jj;

    // Scan from the farthest position inward so the nearest hit after ptr wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = |req;
        j      = 0;
        jj     = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            j = int'(ptr) + off;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IDX_W'(j);
            if (req[jj]) begin
                onehot     = '0;
                onehot[jj] = 1'b1;
                idx        = jj;
            end
        end
    end

endmodule

// File: rtl/cordic_share_arbiter.sv
// Round-robin owner of the shared vectoring/rotation CORDIC pair, with a core
// flush on every handover and per-core outstanding-operation tracking.
module cordic_share_arbiter
    import cordic_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int DATA_WIDTH      = 16,
    parameter int ANGLE_WIDTH     = 16,
    parameter int FLUSH_CYCLES    = 2,
    parameter int MAX_OUTSTANDING = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req,
    output logic [NUM_REQ-1:0]                 grant,
    output logic                               busy,
    output logic                               ovf_err,
    input  logic [NUM_REQ-1:0]                 rq_nrst,
    input  logic [NUM_REQ-1:0]                 rq_vec_en,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      rq_vec_xin,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      rq_vec_yin,
    input  logic [NUM_REQ-1:0]                 rq_rot_en,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      rq_rot_xin,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      rq_rot_yin,
    input  logic [NUM_REQ*ANGLE_WIDTH-1:0]     rq_rot_angle,
    input  logic [NUM_REQ*CORDIC_QUAD_W-1:0]   rq_rot_quad,
    input  logic [NUM_REQ-1:0]                 rq_rot_angle_microRot_n,
    output logic [NUM_REQ-1:0]                 rq_vec_opvld,
    output logic [NUM_REQ-1:0]                 rq_rot_opvld,
    cordic_share_arbiter_if.master             core
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(MAX_OUTSTANDING + 1);
    localparam int FL_W  = clog2(FLUSH_CYCLES + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] owner_oh_q, owner_oh_d, grant_q, grant_d;
    logic [FL_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d, rot_cnt_q, rot_cnt_d;
    logic               ovf_q, ovf_d;
    logic               vec_err, rot_err, nrst_sel, own_active, route_active;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

    // Returns {error, next_count}; a same-cycle issue and return cancel out.
    function automatic logic [CNT_W:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec,
                                                input logic clr);
        if (clr) return '0;
        if (inc && !dec) begin
            if (cnt == CNT_W'(MAX_OUTSTANDING)) return {1'b1, cnt};
            return {1'b0, cnt + 1'b1};
        end
        if (dec && !inc) begin
            if (cnt == '0) return {1'b1, cnt};
            return {1'b0, cnt - 1'b1};
        end
        return {1'b0, cnt};
    endfunction

    assign own_active   = (state_q == ST_OWN);
    assign route_active = own_active || (state_q == ST_DRAIN);

    always_comb begin
        core.cordic_vec_en               = 1'b0;
        core.cordic_vec_xin              = '0;
        core.cordic_vec_yin              = '0;
        core.cordic_rot_en               = 1'b0;
        core.cordic_rot_xin              = '0;
        core.cordic_rot_yin              = '0;
        core.cordic_rot_angle_in         = '0;
        core.cordic_rot_quad_in          = '0;
        core.cordic_rot_angle_microRot_n = 1'b0;
        nrst_sel                         = (state_q != ST_FLUSH);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (own_active && owner_q == IDX_W'(i)) begin
                nrst_sel                         = rq_nrst[i];
                core.cordic_vec_en               = rq_vec_en[i];
                core.cordic_vec_xin              = rq_vec_xin[i*DATA_WIDTH +: DATA_WIDTH];
                core.cordic_vec_yin              = rq_vec_yin[i*DATA_WIDTH +: DATA_WIDTH];
                core.cordic_rot_en               = rq_rot_en[i];
                core.cordic_rot_xin              = rq_rot_xin[i*DATA_WIDTH +: DATA_WIDTH];
                core.cordic_rot_yin              = rq_rot_yin[i*DATA_WIDTH +: DATA_WIDTH];
                core.cordic_rot_angle_in         = rq_rot_angle[i*ANGLE_WIDTH +: ANGLE_WIDTH];
                core.cordic_rot_quad_in          = rq_rot_quad[i*CORDIC_QUAD_W +: CORDIC_QUAD_W];
                core.cordic_rot_angle_microRot_n = rq_rot_angle_microRot_n[i];
            end
        end
        // The core reset must follow rst immediately, not wait for a clock.
        core.cordic_nrst = nrst_sel & ~rst;
    end

    assign rq_vec_opvld = route_active ? (owner_oh_q & {NUM_REQ{core.cordic_vec_opvld}}) : '0;
    assign rq_rot_opvld = route_active ? (owner_oh_q & {NUM_REQ{core.cordic_rot_opvld}}) : '0;

    always_comb begin
        {vec_err, vec_cnt_d} = cnt_next(vec_cnt_q, core.cordic_vec_en,
                                        route_active & core.cordic_vec_opvld, ~nrst_sel);
        {rot_err, rot_cnt_d} = cnt_next(rot_cnt_q, core.cordic_rot_en,
                                        route_active & core.cordic_rot_opvld, ~nrst_sel);
        ovf_d = ovf_q | vec_err | rot_err;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        owner_oh_d  = owner_oh_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d     = pick_idx;
                    owner_oh_d  = pick_oh;
                    rr_ptr_d    = pick_idx;
                    flush_cnt_d = FL_W'(FLUSH_CYCLES - 1);
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    grant_d = owner_oh_q;
                    state_d = ST_OWN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            ST_OWN: begin
                if (!req[owner_q]) begin
                    grant_d = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (vec_cnt_d == '0 && rot_cnt_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            owner_oh_q  <= '0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            grant_q     <= '0;
            flush_cnt_q <= '0;
            vec_cnt_q   <= '0;
            rot_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            owner_oh_q  <= owner_oh_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            flush_cnt_q <= flush_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            rot_cnt_q   <= rot_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q != ST_IDLE);
    assign ovf_err = ovf_q;

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Self-checking bench for cordic_share_arbiter: directed scenarios with
// randomized data and a round-robin reference for owner order.
`timescale 1ns/1ps
module tb_cordic_share_arbiter;

    localparam int NR = 3;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int FL = 2;
    localparam int MO = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req, grant, rq_nrst, rq_vec_en, rq_rot_en, rq_rot_mr;
    logic              busy, ovf_err;
    logic [NR*DW-1:0]  rq_vec_xin, rq_vec_yin, rq_rot_xin, rq_rot_yin;
    logic [NR*AW-1:0]  rq_rot_angle;
    logic [NR*2-1:0]   rq_rot_quad;
    logic [NR-1:0]     rq_vec_opvld, rq_rot_opvld;

    logic [DW-1:0]     vx[NR], vy[NR], rx[NR], ry[NR];
    logic [AW-1:0]     ang[NR];
    logic [1:0]        qd[NR];

    int checks = 0;
    int errors = 0;

    cordic_share_arbiter_if #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) core_if ();

    cordic_share_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW),
        .FLUSH_CYCLES(FL), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .busy(busy), .ovf_err(ovf_err),
        .rq_nrst(rq_nrst), .rq_vec_en(rq_vec_en), .rq_vec_xin(rq_vec_xin), .rq_vec_yin(rq_vec_yin),
        .rq_rot_en(rq_rot_en), .rq_rot_xin(rq_rot_xin), .rq_rot_yin(rq_rot_yin),
        .rq_rot_angle(rq_rot_angle), .rq_rot_quad(rq_rot_quad),
        .rq_rot_angle_microRot_n(rq_rot_mr),
        .rq_vec_opvld(rq_vec_opvld), .rq_rot_opvld(rq_rot_opvld),
        .core(core_if)
    );

    always #5 clk = ~clk;

    // Reference round-robin: first requester after 'last', wrapping.
    function automatic int rr_ref(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        rq_vec_xin   = {vx[2], vx[1], vx[0]};
        rq_vec_yin   = {vy[2], vy[1], vy[0]};
        rq_rot_xin   = {rx[2], rx[1], rx[0]};
        rq_rot_yin   = {ry[2], ry[1], ry[0]};
        rq_rot_angle = {ang[2], ang[1], ang[0]};
        rq_rot_quad  = {qd[2], qd[1], qd[0]};
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NR; i++) begin
            vx[i] = DW'($urandom); vy[i] = DW'($urandom);
            rx[i] = DW'($urandom); ry[i] = DW'($urandom);
            ang[i] = AW'($urandom); qd[i] = 2'($urandom);
        end
        rq_rot_mr = NR'($urandom);
        pack();
    endtask

    task automatic clear_inputs();
        req = '0; rq_nrst = '1; rq_vec_en = '0; rq_rot_en = '0; rq_rot_mr = '0;
        for (int i = 0; i < NR; i++) begin
            vx[i] = '0; vy[i] = '0; rx[i] = '0; ry[i] = '0; ang[i] = '0; qd[i] = '0;
        end
        pack();
        core_if.cordic_vec_opvld = 1'b0;
        core_if.cordic_rot_opvld = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int cyc, output int lows);
        cyc = -1; lows = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (core_if.cordic_nrst === 1'b0) lows++;
            if (grant !== '0) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (busy === 1'b0) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== '0 || busy !== 1'b0 || ovf_err !== 1'b0 || core_if.cordic_nrst !== 1'b0 ||
            core_if.cordic_vec_en !== 1'b0 || core_if.cordic_rot_en !== 1'b0 || core_if.cordic_vec_xin !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: grant=%b busy=%b ovf=%b nrst=%b ven=%b ren=%b expected all 0",
                     grant, busy, ovf_err, core_if.cordic_nrst, core_if.cordic_vec_en, core_if.cordic_rot_en);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (core_if.cordic_nrst !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: nrst=%b busy=%b expected nrst=1 busy=0", core_if.cordic_nrst, busy);
        end
    endtask

    task automatic test_single_vec();
        int cyc, lows, pulses, leak, bad;
        int due[$];
        do_reset();
        req = 3'b001;
        wait_grant(cyc, lows);
        checks++;
        if (cyc != 1 + FL || lows != FL || grant !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_grant: cyc=%0d lows=%0d grant=%b busy=%b expected cyc=%0d lows=%0d grant=001 busy=1",
                     cyc, lows, grant, busy, 1 + FL, FL);
        end
        pulses = 0; leak = 0; bad = 0;
        for (int n = 0; n < 40; n++) begin
            randomize_data();
            rq_vec_en = (n == 0 || n == 3 || n == 6) ? 3'b001 : 3'b000;
            if (rq_vec_en[0]) due.push_back(n + 18);
            core_if.cordic_vec_opvld = (due.size() > 0 && due[0] == n);
            if (core_if.cordic_vec_opvld) void'(due.pop_front());
            #1;
            if (rq_vec_en[0] && (core_if.cordic_vec_en !== 1'b1 || core_if.cordic_vec_xin !== vx[0] ||
                                 core_if.cordic_vec_yin !== vy[0])) bad++;
            if (rq_vec_opvld[0] === 1'b1) pulses++;
            if (rq_vec_opvld[2:1] !== 2'b00) leak++;
            tick();
        end
        rq_vec_en = '0;
        core_if.cordic_vec_opvld = 1'b0;
        checks++;
        if (bad != 0 || pulses != 3 || leak != 0) begin
            errors++;
            $display("[TB] FAIL vec_ops: bad_mux=%0d pulses=%0d leaks=%0d expected 0/3/0", bad, pulses, leak);
        end
        req = '0;
        tick();
        checks++;
        if (grant !== '0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_edge: grant=%b busy=%b expected 000/1", grant, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_empty: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int cyc, lows, last, w;
        logic [NR-1:0] exp_oh;
        do_reset();
        req = 3'b111;
        last = NR - 1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(cyc, lows);
            w = rr_ref(req, last);
            exp_oh = 3'b001 << w;
            checks++;
            if (grant !== exp_oh || cyc != ((k == 0) ? 1 + FL : 2 + FL)) begin
                errors++;
                $display("[TB] FAIL rr_seq%0d: grant=%b gap=%0d expected grant=%b gap=%0d",
                         k, grant, cyc, exp_oh, (k == 0) ? 1 + FL : 2 + FL);
            end
            last = w;
            repeat (5) tick();
            req[w] = 1'b0;
            tick();
            checks++;
            if (grant !== '0) begin
                errors++;
                $display("[TB] FAIL rr_drop%0d: grant=%b expected 000", k, grant);
            end
            req[w] = 1'b1;
        end
        req = '0;
        wait_idle(cyc);
    endtask

    task automatic test_rr_random();
        int cyc, lows, last, w, bad;
        logic [NR-1:0] pat, exp_oh;
        do_reset();
        last = NR - 1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            pat = NR'($urandom_range(1, 7));
            req = pat;
            wait_grant(cyc, lows);
            w = rr_ref(pat, last);
            exp_oh = 3'b001 << w;
            checks++;
            if (grant !== exp_oh) begin
                errors++;
                $display("[TB] FAIL rr_random%0d: req=%b grant=%b expected %b", k, pat, grant, exp_oh);
            end
            last = w;
            repeat ($urandom_range(1, 4)) tick();
            req = '0;
            wait_idle(cyc);
            if (cyc < 0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL rr_random_idle: timeouts=%0d expected 0", bad);
        end
    endtask

    task automatic test_drain();
        int cyc, lows, outstanding, stuck;
        do_reset();
        req = 3'b010;
        wait_grant(cyc, lows);
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("[TB] FAIL drain_owner: grant=%b expected 010", grant);
        end
        outstanding = 0;
        for (int n = 0; n < 3; n++) begin
            rq_rot_en = (n != 1) ? 3'b010 : 3'b000;
            #1;
            if (rq_rot_en[1]) outstanding++;
            tick();
        end
        rq_rot_en = '0;
        req = '0;
        tick();
        checks++;
        if (grant !== '0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_drop: grant=%b busy=%b expected 000/1", grant, busy);
        end
        stuck = 0;
        for (int n = 0; n < 6; n++) begin
            rq_rot_en = (n == 2) ? 3'b010 : 3'b000;
            #1;
            if (core_if.cordic_rot_en !== 1'b0) stuck++;
            tick();
            if (busy !== 1'b1) stuck++;
        end
        rq_rot_en = '0;
        checks++;
        if (stuck != 0) begin
            errors++;
            $display("[TB] FAIL drain_hold: violations=%0d expected 0", stuck);
        end
        while (outstanding > 0) begin
            core_if.cordic_rot_opvld = 1'b1;
            #1;
            checks++;
            if (rq_rot_opvld !== 3'b010) begin
                errors++;
                $display("[TB] FAIL drain_route: rq_rot_opvld=%b expected 010", rq_rot_opvld);
            end
            tick();
            outstanding--;
            core_if.cordic_rot_opvld = 1'b0;
            checks++;
            if (busy !== (outstanding > 0)) begin
                errors++;
                $display("[TB] FAIL drain_busy: busy=%b expected %b", busy, outstanding > 0);
            end
            if (outstanding > 0) tick();
        end
    endtask

    task automatic test_mux();
        int cyc, lows, bad;
        do_reset();
        req = 3'b001;
        wait_grant(cyc, lows);
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            randomize_data();
            rq_vec_en = {1'($urandom), 1'($urandom), 1'b0};
            rq_rot_en = {1'($urandom), 1'($urandom), 1'b0};
            #1;
            if (core_if.cordic_vec_xin !== vx[0] || core_if.cordic_vec_yin !== vy[0] ||
                core_if.cordic_rot_xin !== rx[0] || core_if.cordic_rot_yin !== ry[0] ||
                core_if.cordic_rot_angle_in !== ang[0] || core_if.cordic_rot_quad_in !== qd[0] ||
                core_if.cordic_rot_angle_microRot_n !== rq_rot_mr[0] ||
                core_if.cordic_vec_en !== 1'b0 || core_if.cordic_rot_en !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL mux_random: mismatching_cycles=%0d expected 0", bad);
        end
        vx[0] = 16'h0042; vx[2] = 16'h1234; pack();
        rq_rot_en = '0;
        rq_vec_en = 3'b100;
        #1;
        checks++;
        if (core_if.cordic_vec_xin !== 16'h0042 || core_if.cordic_vec_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nonowner_en: xin=%h en=%b expected 0042/0", core_if.cordic_vec_xin, core_if.cordic_vec_en);
        end
        rq_nrst = 3'b011;
        #1;
        checks++;
        if (core_if.cordic_nrst !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nrst_nonowner: nrst=%b expected 1", core_if.cordic_nrst);
        end
        rq_nrst = 3'b110;
        #1;
        checks++;
        if (core_if.cordic_nrst !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nrst_owner: nrst=%b expected 0", core_if.cordic_nrst);
        end
        rq_nrst = '1;
        tick();
        rq_vec_en = '0;
        req = '0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nonowner_count: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_ovf();
        int cyc, lows, bad;
        do_reset();
        req = 3'b001;
        wait_grant(cyc, lows);
        rq_vec_en = 3'b001;
        repeat (MO) tick();
        rq_vec_en = '0;
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_at_max: ovf=%b expected 0", ovf_err);
        end
        rq_vec_en = 3'b001;
        tick();
        rq_vec_en = '0;
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_over_max: ovf=%b expected 1", ovf_err);
        end
        req = '0;
        tick();
        bad = 0;
        for (int i = 1; i <= MO; i++) begin
            core_if.cordic_vec_opvld = 1'b1;
            tick();
            if (busy !== (i < MO)) bad++;
        end
        core_if.cordic_vec_opvld = 1'b0;
        checks++;
        if (bad != 0 || ovf_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_saturate: busy_errs=%0d ovf=%b expected 0/1", bad, ovf_err);
        end
        do_reset();
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_cleared: ovf=%b expected 0", ovf_err);
        end
        req = 3'b001;
        wait_grant(cyc, lows);
        core_if.cordic_rot_opvld = 1'b1;
        tick();
        core_if.cordic_rot_opvld = 1'b0;
        repeat (3) tick();
        req = '0;
        tick();
        tick();
        checks++;
        if (ovf_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underflow: ovf=%b busy=%b expected 1/0", ovf_err, busy);
        end
    endtask

    task automatic test_flush_drop();
        int cyc, lows;
        do_reset();
        req = 3'b001;
        tick();
        req = '0;
        tick();
        tick();
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("[TB] FAIL flush_drop_grant: grant=%b expected 001", grant);
        end
        tick();
        checks++;
        if (grant !== '0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_drop_drain: grant=%b busy=%b expected 000/1", grant, busy);
        end
        wait_idle(cyc);
        req = 3'b001;
        wait_grant(cyc, lows);
        checks++;
        if (grant !== 3'b001 || cyc != 1 + FL || lows != FL) begin
            errors++;
            $display("[TB] FAIL lone_rerequest: grant=%b cyc=%0d lows=%0d expected 001/%0d/%0d",
                     grant, cyc, lows, 1 + FL, FL);
        end
        req = '0;
        wait_idle(cyc);
    endtask

    task automatic test_rst_mid_own();
        int cyc, lows;
        do_reset();
        req = 3'b010;
        wait_grant(cyc, lows);
        rq_vec_en = 3'b010;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== '0 || core_if.cordic_nrst !== 1'b0 || core_if.cordic_vec_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_own: grant=%b nrst=%b ven=%b expected 000/0/0",
                     grant, core_if.cordic_nrst, core_if.cordic_vec_en);
        end
        tick();
        rst = 1'b0;
        rq_vec_en = '0;
        req = 3'b111;
        wait_grant(cyc, lows);
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("[TB] FAIL rst_rr_restart: grant=%b expected 001", grant);
        end
        req = '0;
        wait_idle(cyc);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_vec();
        test_round_robin();
        test_rr_random();
        test_drain();
        test_mux();
        test_ovf();
        test_flush_drop();
        test_rst_mid_own();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
